// File: rtl/spec_store_buffer.sv
// rtl/spec_store_buffer.sv - speculative store buffer: ROB-ordered commit, flush squash, one-at-a-time drain, load forwarding
// Define SPEC_STORE_BUF_STATS_EN to enable the stat_drained / stat_full_cyc counters.
module spec_store_buffer #(
  parameter int DEPTH       = 8,
  parameter int ROB_ID_SIZE = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [ROB_ID_SIZE-1:0]   enq_rob_id,
  input  logic [ADDR_W-1:0]        enq_addr,
  input  logic [DATA_W-1:0]        enq_wdata,
  input  logic [DATA_W/8-1:0]      enq_wmask,
  input  logic                     commit_valid,
  input  logic [ROB_ID_SIZE-1:0]   commit_rob_id,
  output logic                     commit_err,
  input  logic                     flush,
  output logic                     mem_valid,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [DATA_W/8-1:0]      mem_wmask,
  input  logic                     mem_resp,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [DATA_W/8-1:0]      ld_rmask,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data,
  output logic                     fwd_stall,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [31:0]              stat_drained,
  output logic [31:0]              stat_full_cyc
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam int MW = DATA_W / 8;
  localparam int WA = ADDR_W - 2;
  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  logic [ROB_ID_SIZE-1:0] ent_rob_q  [DEPTH];
  logic [WA-1:0]          ent_addr_q [DEPTH];
  logic [DATA_W-1:0]      ent_data_q [DEPTH];
  logic [MW-1:0]          ent_mask_q [DEPTH];

  logic [PW-1:0]     head_q, head_d, cmt_q, cmt_d, tail_q, tail_d, cnt;
  logic              state_q, state_d;
  logic              commit_err_q, commit_err_d;
  logic [WA-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [MW-1:0]     mem_wmask_q, mem_wmask_d;
  logic              enq_fire, cmt_ok, retire;
  logic [IW-1:0]     fwd_idx;
  logic [MW-1:0]     fwd_ov;
  logic              unused_bits;

  assign cnt        = tail_q - head_q;
  assign count      = cnt;
  assign full       = (cnt == PW'(DEPTH));
  assign empty      = (head_q == tail_q);
  assign enq_ready  = !full;
  assign enq_fire   = enq_valid && !full && !flush;
  assign cmt_ok     = commit_valid && (cmt_q != tail_q) &&
                      (ent_rob_q[cmt_q[IW-1:0]] == commit_rob_id);
  assign retire     = (state_q == ST_BUSY) && mem_resp;
  assign commit_err = commit_err_q;
  assign mem_valid  = (state_q == ST_BUSY);
  assign mem_addr   = {mem_addr_q, 2'b00};
  assign mem_wdata  = mem_wdata_q;
  assign mem_wmask  = mem_wmask_q;
  assign unused_bits = ^{enq_addr[1:0], ld_addr[1:0]};

  always_comb begin
    head_d       = head_q + PW'(retire);
    cmt_d        = cmt_q + PW'(cmt_ok);
    // Flush rewinds tail to the post-commit boundary, so a same-cycle commit survives.
    tail_d       = flush ? cmt_d : tail_q + PW'(enq_fire);
    commit_err_d = commit_valid && !cmt_ok;
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wmask_d  = mem_wmask_q;
    if (state_q == ST_IDLE) begin
      if (head_q != cmt_q) begin
        state_d     = ST_BUSY;
        mem_addr_d  = ent_addr_q[head_q[IW-1:0]];
        mem_wdata_d = ent_data_q[head_q[IW-1:0]];
        mem_wmask_d = ent_mask_q[head_q[IW-1:0]];
      end
    end else if (mem_resp) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q       <= '0;
      cmt_q        <= '0;
      tail_q       <= '0;
      state_q      <= ST_IDLE;
      commit_err_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
    end else begin
      head_q       <= head_d;
      cmt_q        <= cmt_d;
      tail_q       <= tail_d;
      state_q      <= state_d;
      commit_err_q <= commit_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      ent_rob_q[tail_q[IW-1:0]]  <= enq_rob_id;
      ent_addr_q[tail_q[IW-1:0]] <= enq_addr[ADDR_W-1:2];
      ent_data_q[tail_q[IW-1:0]] <= enq_wdata;
      ent_mask_q[tail_q[IW-1:0]] <= enq_wmask;
    end
  end

  // Oldest-to-youngest scan; a later match overrides, so the youngest overlapping store decides.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_stall = 1'b0;
    fwd_data  = '0;
    fwd_idx   = '0;
    fwd_ov    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = IW'(head_q + PW'(i));
      fwd_ov  = ent_mask_q[fwd_idx] & ld_rmask;
      if ((PW'(i) < cnt) && (ent_addr_q[fwd_idx] == ld_addr[ADDR_W-1:2]) && (fwd_ov != '0)) begin
        fwd_hit   = (fwd_ov == ld_rmask);
        fwd_stall = (fwd_ov != ld_rmask);
        fwd_data  = (fwd_ov == ld_rmask) ? ent_data_q[fwd_idx] : '0;
      end
    end
  end

`ifdef SPEC_STORE_BUF_STATS_EN
  logic [31:0] stat_drained_q, stat_drained_d, stat_full_q, stat_full_d;

  always_comb begin
    stat_drained_d = stat_drained_q + 32'(retire);
    stat_full_d    = stat_full_q + 32'(full);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_drained_q <= '0;
      stat_full_q    <= '0;
    end else begin
      stat_drained_q <= stat_drained_d;
      stat_full_q    <= stat_full_d;
    end
  end

  assign stat_drained  = stat_drained_q;
  assign stat_full_cyc = stat_full_q;
`else
  assign stat_drained  = '0;
  assign stat_full_cyc = '0;
`endif

endmodule
